// File: rtl/bch_enc_serial.sv
// Bit-serial systematic BCH encoder: forwards K message bits, then appends P parity bits from an LFSR.
// Optional abort port enabled by defining BCH_ENC_ABORT_EN.
module bch_enc_serial #(
  parameter int             K        = 7,
  parameter int             P        = 8,
  parameter logic [P-1:0]   GEN_POLY = 8'hD1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  output logic out_bit,
  input  logic out_ready,
  output logic out_first,
  output logic out_last,
`ifdef BCH_ENC_ABORT_EN
  input  logic abort,
`endif
  output logic busy
);

  localparam int MAXKP = (K > P) ? K : P;
  localparam int CW    = $clog2(MAXKP + 1);

  localparam logic [0:0] ST_MSG = 1'b0;
  localparam logic [0:0] ST_PAR = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [P-1:0]  r_lfsr;
  logic          r_out_valid;
  logic          r_out_bit;
  logic          r_out_first;
  logic          r_out_last;

  logic          w_abort;
  logic          w_adv;
  logic          w_accept;
  logic          w_fb;
  logic          w_msg_end;
  logic          w_par_end;
  logic [CW-1:0] w_cnt_inc;

`ifdef BCH_ENC_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // The holder may load a new bit when it is empty or being drained this cycle.
  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = reset && !w_abort && (r_state == ST_MSG) && w_adv;
  assign w_accept  = in_valid && in_ready;
  assign w_fb      = in_bit ^ r_lfsr[P-1];
  assign w_msg_end = (r_cnt == CW'(K - 1));
  assign w_par_end = (r_cnt == CW'(P - 1));
  assign w_cnt_inc = r_cnt + CW'(1);

  assign busy      = reset && ((r_cnt != '0) || (r_state == ST_PAR));
  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_MSG;
      r_cnt       <= '0;
      r_lfsr      <= '0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_abort) begin
      r_state     <= ST_MSG;
      r_cnt       <= '0;
      r_lfsr      <= '0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (r_state == ST_MSG) begin
      if (w_accept) begin
        r_lfsr      <= (r_lfsr << 1) ^ (w_fb ? GEN_POLY : '0);
        r_out_bit   <= in_bit;
        r_out_first <= (r_cnt == '0);
        r_out_last  <= 1'b0;
        r_out_valid <= 1'b1;
        if (w_msg_end) begin
          r_cnt   <= '0;
          r_state <= ST_PAR;
        end else begin
          r_cnt   <= w_cnt_inc;
        end
      end else if (w_adv) begin
        r_out_valid <= 1'b0;
      end
    end else begin
      // Shifting out the MSB leaves the register all-zero after the last parity bit.
      if (w_adv) begin
        r_out_bit   <= r_lfsr[P-1];
        r_lfsr      <= r_lfsr << 1;
        r_out_valid <= 1'b1;
        r_out_first <= 1'b0;
        r_out_last  <= w_par_end;
        if (w_par_end) begin
          r_cnt   <= '0;
          r_state <= ST_MSG;
        end else begin
          r_cnt   <= w_cnt_inc;
        end
      end
    end
  end

endmodule
